// File: rtl/rr_arbiter8.sv
// rtl/rr_arbiter8.sv - eight-way round-robin arbiter with hold timeout and selectable grant polarity
module rr_arbiter8 #(
  parameter int HOLD_MAX = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic       i_opt,
  input  logic [7:0] i_req,
  output logic [2:0] o_gnt_sel,
  output logic [7:0] o_gnt,
  output logic       o_gnt_vld,
  output logic       o_timeout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Last cycle of a full-length grant; only meaningful when the timeout is enabled.
  localparam bit         TIMEOUT_EN = (HOLD_MAX != 0);
  localparam logic [7:0] HOLD_LAST  = (HOLD_MAX > 0) ? 8'(HOLD_MAX - 1) : 8'd0;

  state_t     state_q, state_d;
  logic [7:0] onehot_q, onehot_d;
  logic [2:0] sel_q, sel_d;
  logic [2:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;

  logic       win_found;
  logic [2:0] win_idx;
  logic       req_drop;
  logic       hold_exp;

  // Shared 3-to-8 select decode.
  function automatic logic [7:0] decode3to8(input logic [2:0] idx);
    decode3to8 = 8'h01 << idx;
  endfunction

  // Rotating priority search: starts just after the last served index, so that index ranks last.
  always_comb begin
    logic [2:0] idx;
    win_found = 1'b0;
    win_idx   = 3'd0;
    idx       = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      idx = last_q + 3'(i);
      if (!win_found && i_req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Release causes; a dropped request outranks the timeout.
  always_comb begin
    req_drop = !i_req[sel_q];
    hold_exp = TIMEOUT_EN && (cnt_q == HOLD_LAST);
  end

  // Next-state logic for the IDLE/GRANT controller.
  always_comb begin
    state_d   = state_q;
    onehot_d  = onehot_q;
    sel_d     = sel_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        onehot_d = 8'h00;
        if (i_en && win_found) begin
          sel_d    = win_idx;
          onehot_d = decode3to8(win_idx);
          cnt_d    = 8'd0;
          state_d  = ST_GRANT;
        end
      end
      ST_GRANT: begin
        cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
        if (req_drop || hold_exp) begin
          last_d    = sel_q;
          onehot_d  = 8'h00;
          state_d   = ST_IDLE;
          timeout_d = !req_drop;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        onehot_d = 8'h00;
      end
    endcase
  end

  // State registers; reset leaves last_q at 7 so the first search begins at index 0.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      onehot_q  <= 8'h00;
      sel_q     <= 3'd0;
      last_q    <= 3'd7;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      onehot_q  <= onehot_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_gnt_sel = sel_q;
  assign o_gnt_vld = (state_q == ST_GRANT);
  assign o_timeout = timeout_q;
  assign o_gnt     = i_opt ? onehot_q : ~onehot_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// tb/tb_rr_arbiter8.sv - directed self-checking bench for rr_arbiter8
module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       opt;
  logic [7:0] req;

  logic [2:0] sel4, sel16, sel0;
  logic [7:0] gnt4, gnt16, gnt0;
  logic       vld4, vld16, vld0;
  logic       to4, to16, to0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rr_arbiter8 #(.HOLD_MAX(4)) u4 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_opt(opt), .i_req(req),
    .o_gnt_sel(sel4), .o_gnt(gnt4), .o_gnt_vld(vld4), .o_timeout(to4)
  );

  rr_arbiter8 #(.HOLD_MAX(16)) u16 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_opt(opt), .i_req(req),
    .o_gnt_sel(sel16), .o_gnt(gnt16), .o_gnt_vld(vld16), .o_timeout(to16)
  );

  rr_arbiter8 #(.HOLD_MAX(0)) u0 (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_opt(opt), .i_req(req),
    .o_gnt_sel(sel0), .o_gnt(gnt0), .o_gnt_vld(vld0), .o_timeout(to0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b1;
    opt = 1'b0;
    req = 8'h00;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({vld4, sel4, gnt4, to4} !== {1'b0, 3'd0, 8'hFF, 1'b0}) begin
      errors++;
      $display("FAIL reset_state got vld=%0b sel=%0d gnt=%h to=%0b exp vld=0 sel=0 gnt=ff to=0", vld4, sel4, gnt4, to4);
    end
    opt = 1'b1;
    #1;
    checks++;
    if (gnt4 !== 8'h00) begin
      errors++;
      $display("FAIL reset_gnt_high got %h exp 00", gnt4);
    end
    opt = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h08;
    tick();
    checks++;
    if ({vld4, sel4, gnt4} !== {1'b1, 3'd3, 8'hF7}) begin
      errors++;
      $display("FAIL single_grant got vld=%0b sel=%0d gnt=%h exp vld=1 sel=3 gnt=f7", vld4, sel4, gnt4);
    end
    opt = 1'b1;
    #1;
    checks++;
    if (gnt4 !== 8'h08) begin
      errors++;
      $display("FAIL single_polarity got %h exp 08", gnt4);
    end
    opt = 1'b0;
  endtask

  task automatic test_rotation();
    logic [7:0] exp_gnt;
    do_reset();
    req = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_gnt = ~(8'h01 << (k % 8));
      tick();
      checks++;
      if ({vld4, sel4, gnt4, to4} !== {1'b1, 3'(k % 8), exp_gnt, 1'b0}) begin
        errors++;
        $display("FAIL rotation_grant%0d got vld=%0b sel=%0d gnt=%h to=%0b exp vld=1 sel=%0d gnt=%h to=0",
                 k, vld4, sel4, gnt4, to4, k % 8, exp_gnt);
      end
      repeat (3) tick();
      checks++;
      if (vld4 !== 1'b1) begin
        errors++;
        $display("FAIL rotation_hold%0d got vld=%0b exp 1", k, vld4);
      end
      tick();
      checks++;
      if ({vld4, to4} !== 2'b01) begin
        errors++;
        $display("FAIL rotation_timeout%0d got vld=%0b to=%0b exp vld=0 to=1", k, vld4, to4);
      end
    end
  endtask

  task automatic test_wrap_skip();
    do_reset();
    req = 8'h40;
    tick();
    checks++;
    if ({vld4, sel4} !== {1'b1, 3'd6}) begin
      errors++;
      $display("FAIL wrap_setup got vld=%0b sel=%0d exp vld=1 sel=6", vld4, sel4);
    end
    req = 8'h05;
    tick();
    checks++;
    if ({vld4, to4} !== 2'b00) begin
      errors++;
      $display("FAIL wrap_release got vld=%0b to=%0b exp vld=0 to=0", vld4, to4);
    end
    tick();
    checks++;
    if ({vld4, sel4} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL wrap_first got vld=%0b sel=%0d exp vld=1 sel=0", vld4, sel4);
    end
    repeat (4) tick();
    tick();
    checks++;
    if ({vld4, sel4} !== {1'b1, 3'd2}) begin
      errors++;
      $display("FAIL wrap_second got vld=%0b sel=%0d exp vld=1 sel=2", vld4, sel4);
    end
    repeat (4) tick();
    tick();
    checks++;
    if ({vld4, sel4} !== {1'b1, 3'd0}) begin
      errors++;
      $display("FAIL wrap_third got vld=%0b sel=%0d exp vld=1 sel=0", vld4, sel4);
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req = 8'h20;
    tick();
    checks++;
    if ({vld16, sel16} !== {1'b1, 3'd5}) begin
      errors++;
      $display("FAIL early_grant got vld=%0b sel=%0d exp vld=1 sel=5", vld16, sel16);
    end
    tick();
    req = 8'h00;
    tick();
    checks++;
    if ({vld16, to16, sel16} !== {1'b0, 1'b0, 3'd5}) begin
      errors++;
      $display("FAIL early_release got vld=%0b to=%0b sel=%0d exp vld=0 to=0 sel=5", vld16, to16, sel16);
    end
    req = 8'h60;
    tick();
    checks++;
    if ({vld16, sel16} !== {1'b1, 3'd6}) begin
      errors++;
      $display("FAIL early_last got vld=%0b sel=%0d exp vld=1 sel=6", vld16, sel16);
    end
  endtask

  task automatic test_both_release();
    do_reset();
    req = 8'h01;
    tick();
    repeat (3) tick();
    req = 8'h00;
    tick();
    checks++;
    if ({vld4, to4} !== 2'b00) begin
      errors++;
      $display("FAIL both_release got vld=%0b to=%0b exp vld=0 to=0", vld4, to4);
    end
  endtask

  task automatic test_enable_and_disable();
    logic bad;
    do_reset();
    en  = 1'b0;
    req = 8'h01;
    bad = 1'b0;
    repeat (3) begin
      tick();
      if (vld0 !== 1'b0 || vld4 !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL en_gating got a grant with en=0, exp none");
    end
    en = 1'b1;
    tick();
    checks++;
    if ({vld0, sel0, vld4} !== {1'b1, 3'd0, 1'b1}) begin
      errors++;
      $display("FAIL en_grant got vld0=%0b sel0=%0d vld4=%0b exp 1 0 1", vld0, sel0, vld4);
    end
    en  = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (vld0 !== 1'b1 || to0 !== 1'b0) bad = 1'b1;
      if (i == 2) begin
        checks++;
        if (vld4 !== 1'b1) begin
          errors++;
          $display("FAIL en_persist got vld4=%0b exp 1", vld4);
        end
      end
      if (i == 3) begin
        checks++;
        if ({vld4, to4} !== 2'b01) begin
          errors++;
          $display("FAIL en_timeout got vld4=%0b to4=%0b exp 0 1", vld4, to4);
        end
      end
      if (i == 10) begin
        checks++;
        if ({vld4, to4} !== 2'b00) begin
          errors++;
          $display("FAIL en_no_regrant got vld4=%0b to4=%0b exp 0 0", vld4, to4);
        end
      end
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL no_timeout got release or pulse with HOLD_MAX=0, exp held grant");
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 8'h08;
    tick();
    req = 8'h00;
    tick();
    req = 8'h20;
    tick();
    tick();
    tick();
    rst = 1'b1;
    req = 8'h81;
    tick();
    checks++;
    if ({vld16, gnt16, sel16, to16} !== {1'b0, 8'hFF, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL midrst_state got vld=%0b gnt=%h sel=%0d to=%0b exp vld=0 gnt=ff sel=0 to=0",
               vld16, gnt16, sel16, to16);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({vld16, sel16, gnt16} !== {1'b1, 3'd0, 8'hFE}) begin
      errors++;
      $display("FAIL midrst_regrant got vld=%0b sel=%0d gnt=%h exp vld=1 sel=0 gnt=fe", vld16, sel16, gnt16);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before bench completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    opt = 1'b0;
    req = 8'h00;
    test_reset();
    test_single();
    test_rotation();
    test_wrap_skip();
    test_early_release();
    test_both_release();
    test_enable_and_disable();
    test_reset_mid_grant();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rr_arbiter8.md
# rr_arbiter8

Round-robin arbiter sharing one resource among eight requesters, built around the 3-to-8 select decode used throughout the design. It registers a 3-bit grant index plus a one-hot grant vector whose polarity is selected at run time (active-low by default, matching the decoder family). A per-grant hold timeout keeps one requester from monopolising the resource. It sits between the requester bank and the shared datapath's select/enable inputs.

## Interface
- HOLD_MAX, default 16: maximum grant length in cycles; 0 disables the timeout; legal range 0..255.
- i_clk  input  1  clock, all logic on rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_en  input  1  arbitration enable; gates new grants only.
- i_opt  input  1  grant polarity: 0 = o_gnt active-low, 1 = o_gnt active-high.
- i_req  input  8  request vector, bit k = requester k, level-sensitive.
- o_gnt_sel  output  3  index of the granted requester.
- o_gnt  output  8  one-hot grant, polarity per i_opt.
- o_gnt_vld  output  1  a grant is active.
- o_timeout  output  1  one-cycle pulse when a grant ends by timeout.

## Operation
- Internal registers: state (IDLE, GRANT), r_onehot[7:0], r_sel[2:0], r_last[2:0] (last served index), r_cnt[7:0] (hold counter).
- o_gnt = i_opt ? r_onehot : ~r_onehot. This is the only combinational output path, and i_opt takes effect immediately.
- Reset values: state IDLE, r_onehot 0, o_gnt_sel 0, o_gnt_vld 0, o_timeout 0, r_cnt 0, r_last 7. With i_opt=0, o_gnt = 8'hFF; with i_opt=1, o_gnt = 8'h00.
- Priority search: starts at (r_last+1) mod 8, ascending, wraps 7->0. The first set i_req bit wins, so r_last itself has lowest priority.
- IDLE:
  - If i_en=1 and i_req≠0: load r_sel and o_gnt_sel with the winner, set r_onehot = 1<<winner, set o_gnt_vld=1, clear r_cnt, go to GRANT.
  - Otherwise stay in IDLE with o_gnt_vld=0 and r_onehot=0.
- GRANT:
  - r_cnt increments each cycle, saturating at 255.
  - Release condition: i_req[r_sel]=0, OR (HOLD_MAX≠0 AND r_cnt == HOLD_MAX-1).
  - On release: set r_last=r_sel, clear r_onehot and o_gnt_vld, go to IDLE. o_gnt_sel holds its last value.
  - o_timeout=1 for one cycle only if the timeout condition caused the release.
  - If both release conditions are true in the same cycle, the drop of i_req has priority and o_timeout stays 0.
  - i_en is ignored in GRANT; an active grant always completes.
- Other requesters' bits are ignored while in GRANT. A requester that deasserts before being served is simply skipped.
- A timed-out requester keeping i_req high is re-eligible, but only after all other active requesters in rotation order.

## Timing
- Grant latency: a request sampled in IDLE on edge N gives o_gnt_vld=1 and a valid o_gnt_sel/o_gnt after edge N, i.e. in cycle N+1.
- Grant length:
  - with i_req held and a timeout: exactly HOLD_MAX cycles of o_gnt_vld=1;
  - release by dropped request: the grant drops on the edge after i_req[r_sel] is sampled low.
- Minimum one idle cycle (o_gnt_vld=0) between consecutive grants, including a re-grant to the same index.
- o_timeout is asserted in the first IDLE cycle after the timeout release, coincident with o_gnt_vld=0.
- Reset mid-grant: on the edge where i_rst=1 is sampled, all registers take their reset values. No o_timeout pulse. The next grant search starts at index 0.
- i_rst has priority over every other input.

## Test plan
- Reset then single request: i_rst 1 for 2 cycles, i_opt=0, i_req=8'h08 -> one cycle later o_gnt_vld=1, o_gnt_sel=3, o_gnt=8'hF7. Set i_opt=1 -> o_gnt=8'h08 in the same cycle.
- Rotation: i_req=8'hFF held, HOLD_MAX=4 -> grants go to 0,1,...,7,0. Each grant lasts 4 cycles, followed by 1 idle cycle and an o_timeout pulse.
- Wrap and skip: r_last=6, i_req=8'h05 -> grant index 0, then index 2, then index 0.
- Early release: grant to 5, drop i_req[5] after 2 cycles, HOLD_MAX=16 -> o_gnt_vld falls the next edge, o_timeout stays 0, r_last=5.
- Enable gating and timeout disable:
  - i_en=0 with i_req=8'h01 -> no grant.
  - Raise i_en -> grant one cycle later; lower i_en during the grant -> the grant persists.
  - HOLD_MAX=0 with the request held 300 cycles -> no release, no o_timeout.
- Reset mid-grant: assert i_rst during the 3rd grant cycle -> next cycle o_gnt_vld=0, o_gnt=8'hFF (i_opt=0), o_gnt_sel=0, o_timeout=0. With i_req=8'h81, the first post-reset grant goes to 0.
